// File: rtl/uart_irq_pkg.sv
// UART interrupt controller shared definitions.
// Source indices, interrupt ID type and priority encoder.
package uart_irq_pkg;

    localparam int SRC_RX_THR   = 0;
    localparam int SRC_RX_TO    = 1;
    localparam int SRC_TX_THR   = 2;
    localparam int SRC_EXT_BASE = 3;

    // Upper bound on sources handled by the encoder.
    localparam int MAX_SRC = 64;
    localparam int MAX_IDW = 7;

    typedef logic [MAX_IDW-1:0] irq_id_t;

    // Index+1 of the highest set bit; 0 when none set.
    function automatic irq_id_t prio_enc(input logic [MAX_SRC-1:0] v);
        irq_id_t id;
        id = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (v[i]) id = irq_id_t'(i + 1);
        end
        return id;
    endfunction

endpackage

// File: rtl/uart_irq_ctrl_to_cnt.sv
// RX character timeout counter: clear beats increment, saturates at thr_i.
// Ports: clk_i, rst_i, clr_i, tick_i, thr_i -> cnt_o.
module uart_irq_to_cnt #(
    parameter int TO_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            tick_i,
    input  logic [TO_W-1:0] thr_i,
    output logic [TO_W-1:0] cnt_o
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q < thr_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: 3 built-in + EXT_SRC external sources, sticky
// pending with W1C, edge/level set, priority ID. Optional macro
// UART_IRQ_COALESCE_EN adds coal_i holdoff on irq_o.
// Ports: en_i/mode_i/clr_i per source, FIFO levels/thresholds, timeout
// inputs, ext_src_i -> pend_o, id_o, irq_o.
module uart_irq_ctrl
    import uart_irq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int LOG_FIFO_DEPTH = $clog2(FIFO_DEPTH),
    parameter int EXT_SRC        = 4,
    parameter int TO_W           = 8,
    parameter int NSRC           = 3 + EXT_SRC,
    parameter int IDW            = $clog2(NSRC + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NSRC-1:0]         en_i,
    input  logic [NSRC-1:0]         mode_i,
    input  logic [NSRC-1:0]         clr_i,
    input  logic [EXT_SRC-1:0]      ext_src_i,
    input  logic [LOG_FIFO_DEPTH:0] rx_elem_i,
    input  logic [LOG_FIFO_DEPTH:0] tx_elem_i,
    input  logic [LOG_FIFO_DEPTH:0] rx_thr_i,
    input  logic [LOG_FIFO_DEPTH:0] tx_thr_i,
    input  logic                    rx_act_i,
    input  logic                    char_tick_i,
    input  logic [TO_W-1:0]         to_thr_i,
    output logic [NSRC-1:0]         pend_o,
    output logic [IDW-1:0]          id_o,
    output logic                    irq_o
`ifdef UART_IRQ_COALESCE_EN
    ,
    input  logic [TO_W-1:0]         coal_i
`endif
);

    logic [NSRC-1:0]    raw;
    logic [NSRC-1:0]    raw_q;
    logic [NSRC-1:0]    set;
    logic [NSRC-1:0]    pend_q;
    logic [NSRC-1:0]    pend_d;
    logic [NSRC-1:0]    masked;
    logic [MAX_SRC-1:0] masked_w;
    irq_id_t            id_full;
    logic [TO_W-1:0]    to_cnt;
    logic               rx_empty;

    assign rx_empty = (rx_elem_i == '0);

    uart_irq_to_cnt #(
        .TO_W (TO_W)
    ) u_to_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (rx_act_i || rx_empty),
        .tick_i (char_tick_i),
        .thr_i  (to_thr_i),
        .cnt_o  (to_cnt)
    );

    always_comb begin
        raw = '0;
        raw[SRC_RX_THR] = (rx_thr_i != '0) && (rx_elem_i >= rx_thr_i);
        raw[SRC_RX_TO]  = (to_thr_i != '0) && !rx_empty
                          && (to_cnt == to_thr_i);
        raw[SRC_TX_THR] = (tx_elem_i <= tx_thr_i);
        raw[SRC_EXT_BASE +: EXT_SRC] = ext_src_i;
    end

    // Set wins over a same-cycle clear.
    assign set    = (mode_i & raw & ~raw_q) | (~mode_i & raw);
    assign pend_d = set | (pend_q & ~clr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            raw_q  <= '0;
            pend_q <= '0;
        end else begin
            raw_q  <= raw;
            pend_q <= pend_d;
        end
    end

    assign masked = pend_q & en_i;

    always_comb begin
        masked_w = '0;
        masked_w[NSRC-1:0] = masked;
    end

    assign id_full = prio_enc(masked_w);
    assign id_o    = id_full[IDW-1:0];
    assign pend_o  = pend_q;

`ifdef UART_IRQ_COALESCE_EN
    // Cycles masked has been continuously non-zero, saturating at coal_i.
    logic [TO_W-1:0] hold_q;
    logic [TO_W-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (masked == '0) begin
            hold_d = '0;
        end else if (hold_q < coal_i) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) hold_q <= '0;
        else       hold_q <= hold_d;
    end

    assign irq_o = (masked != '0) && (hold_q >= coal_i);
`else
    assign irq_o = (masked != '0);
`endif

endmodule
